time_display_mux: RTL

Downstream display stage for the stopwatch/clock counters. Takes binary hours/minutes/seconds and samples them once per scan frame. Converts them to BCD with a sequential subtractive converter. Drives a 4-digit, common-anode, time-multiplexed 7-segment display (HH:MM or MM:SS page) with registered, glitch-free outputs.

---
 rtl/disp_pkg.sv | 47 ++++
 rtl/time_display_mux_if.sv | 23 ++
 rtl/time_display_mux_bin2bcd_seq.sv | 42 ++++
 rtl/time_display_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, seven-segment codes and converter FSM states for the
// time display path.
package disp_pkg;

    localparam int unsigned MIN_SCAN_DIV = 32;
    localparam int unsigned NUM_DIGITS   = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        CONV_H,
        CONV_M,
        CONV_S,
        PEND
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/time_display_mux_if.sv
// Time-in / segment-out bus between the counters and the display driver.
interface time_display_mux_if;

    logic [4:0] hours_i;
    logic [5:0] mins_i;
    logic [5:0] secs_i;
    logic       page_i;
    logic       en_i;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    modport master (
        output hours_i, mins_i, secs_i, page_i, en_i,
        input  seg_o, an_o, dp_o
    );

    modport slave (
        input  hours_i, mins_i, secs_i, page_i, en_i,
        output seg_o, an_o, dp_o
    );

endinterface

// File: rtl/time_display_mux_bin2bcd_seq.sv
// Sequential subtract-10 binary to BCD converter for values 0..63;
// takes tens+1 cycles after start, done marks the final cycle.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] value,
    output logic       busy,
    output logic       done,
    output logic [2:0] tens,
    output logic [3:0] ones
);

    logic [5:0] rem_q;
    logic [2:0] tens_q;
    logic       busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            tens_q <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= value;
            tens_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (rem_q >= 6'd10) begin
                rem_q  <= rem_q - 6'd10;
                tens_q <= tens_q + 3'd1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (rem_q < 6'd10);
    assign tens = tens_q;
    assign ones = rem_q[3:0];

endmodule

// File: rtl/time_display_mux.sv
// Four-digit multiplexed 7-segment driver for HH:MM / MM:SS pages.
// Optional DISP_LEADING_ZERO_BLANK_EN blanks a zero in the leftmost digit.
module time_display_mux
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset,
    time_display_mux_if.slave  bus
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    if (SCAN_DIV < MIN_SCAN_DIV) begin : g_scan_div_check
        $error("SCAN_DIV must be at least %0d", MIN_SCAN_DIV);
    end

    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          first_q;
    logic          tc;
    logic          frame_start;

    logic [5:0]    snap_m, snap_s;
    logic          snap_p;

    conv_state_t   state_q, state_d;
    logic          conv_start, conv_busy, conv_done;
    logic [5:0]    conv_val;
    logic [2:0]    conv_tens;
    logic [3:0]    conv_ones;

    logic [3:0]    h_t, h_o, m_t, m_o, s_t, s_o;
    logic [3:0]    pend_q [NUM_DIGITS];
    logic [3:0]    disp_q [NUM_DIGITS];

    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          dp_q;

    assign tc          = (cnt_q == CW'(SCAN_DIV - 1));
    assign frame_start = first_q || (tc && (idx_q == 2'd3));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (tc) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Hours are consumed by the converter on the frame-start edge itself,
    // so only minutes, seconds and page need holding for later states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_m <= '0;
            snap_s <= '0;
            snap_p <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) disp_q[i] <= '0;
        end else if (frame_start) begin
            snap_m <= bus.mins_i;
            snap_s <= bus.secs_i;
            snap_p <= bus.page_i;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) disp_q[i] <= pend_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_val   = {1'b0, bus.hours_i};
        case (state_q)
            IDLE: begin
                if (frame_start && !conv_busy) begin
                    state_d    = CONV_H;
                    conv_start = 1'b1;
                end
            end
            CONV_H: begin
                if (conv_done) begin
                    state_d    = CONV_M;
                    conv_start = 1'b1;
                    conv_val   = snap_m;
                end
            end
            CONV_M: begin
                if (conv_done) begin
                    state_d    = CONV_S;
                    conv_start = 1'b1;
                    conv_val   = snap_s;
                end
            end
            CONV_S:  if (conv_done) state_d = PEND;
            PEND:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (conv_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_t <= '0; h_o <= '0;
            m_t <= '0; m_o <= '0;
            s_t <= '0; s_o <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) pend_q[i] <= '0;
        end else begin
            if (conv_done) begin
                case (state_q)
                    CONV_H:  begin h_t <= {1'b0, conv_tens}; h_o <= conv_ones; end
                    CONV_M:  begin m_t <= {1'b0, conv_tens}; m_o <= conv_ones; end
                    CONV_S:  begin s_t <= {1'b0, conv_tens}; s_o <= conv_ones; end
                    default: ;
                endcase
            end
            if (state_q == PEND) begin
                if (snap_p) begin
                    pend_q[3] <= m_t; pend_q[2] <= m_o;
                    pend_q[1] <= s_t; pend_q[0] <= s_o;
                end else begin
                    pend_q[3] <= h_t; pend_q[2] <= h_o;
                    pend_q[1] <= m_t; pend_q[0] <= m_o;
                end
            end
        end
    end

    always_comb begin
        cur_digit = disp_q[idx_q];
        cur_seg   = seg_encode(cur_digit);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (cur_digit == 4'd0)) cur_seg = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else if (!bus.en_i) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= cur_seg;
            an_q  <= ~(4'b0001 << idx_q);
            dp_q  <= (idx_q != 2'd2);
        end
    end

    assign bus.seg_o = seg_q;
    assign bus.an_o  = an_q;
    assign bus.dp_o  = dp_q;

endmodule
